// File: rtl/pov_pkg.sv
// Shared types and constants for the POV character column path.
// Font ROM addressing helper lives here so the sequencer and ROM agree on layout.
package pov_pkg;

    localparam int ROWS      = 7;
    localparam int FONT_COLS = 5;
    localparam int ROM_DEPTH = 480;
    localparam int ROM_AW    = 9;

    localparam logic [6:0] ASCII_FIRST = 7'h20;
    localparam logic [6:0] ASCII_LAST  = 7'h7E;

    typedef logic [6:0]        ascii_t;
    typedef logic [2:0]        col_t;
    typedef logic [1:0]        gap_t;
    typedef logic [ROM_AW-1:0] rom_addr_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_LOAD  = 3'd2,
        ST_WAIT  = 3'd3,
        ST_GAP   = 3'd4
    } state_e;

    // Non-printable codes map past the end of the ROM so they read back blank.
    function automatic rom_addr_t glyph_addr(input ascii_t code, input col_t col);
        rom_addr_t base;
        if ((code >= ASCII_FIRST) && (code <= ASCII_LAST)) begin
            base       = rom_addr_t'(code - ASCII_FIRST);
            glyph_addr = (base * rom_addr_t'(FONT_COLS)) + rom_addr_t'(col);
        end else begin
            glyph_addr = '1;
        end
    endfunction

endpackage

// File: rtl/font_rom_5x7.sv
// 480 x 7-bit registered font ROM (5 columns per glyph, bit0 = top row).
// One cycle read latency; addresses outside the table return 0.
module font_rom_5x7
    import pov_pkg::*;
(
    input  logic              Clock,
    input  logic              Reset,
    input  logic [ROM_AW-1:0] Addr,
    output logic [6:0]        Data
);

    logic [6:0]  glyph_idx_s;
    logic [2:0]  glyph_col_s;
    logic [34:0] glyph_bits_s;
    logic [6:0]  data_d;
    logic [6:0]  data_q;

    // Glyph bitmap for character index (code - 0x20); leftmost column in the MSBs.
    function automatic logic [34:0] glyph_bits(input logic [6:0] idx);
        case (idx)
            7'd1:  glyph_bits = {7'h00, 7'h00, 7'h5F, 7'h00, 7'h00};
            7'd2:  glyph_bits = {7'h00, 7'h07, 7'h00, 7'h07, 7'h00};
            7'd3:  glyph_bits = {7'h14, 7'h7F, 7'h14, 7'h7F, 7'h14};
            7'd4:  glyph_bits = {7'h24, 7'h2A, 7'h7F, 7'h2A, 7'h12};
            7'd5:  glyph_bits = {7'h23, 7'h13, 7'h08, 7'h64, 7'h62};
            7'd6:  glyph_bits = {7'h36, 7'h49, 7'h56, 7'h20, 7'h50};
            7'd7:  glyph_bits = {7'h00, 7'h08, 7'h07, 7'h03, 7'h00};
            7'd8:  glyph_bits = {7'h00, 7'h1C, 7'h22, 7'h41, 7'h00};
            7'd9:  glyph_bits = {7'h00, 7'h41, 7'h22, 7'h1C, 7'h00};
            7'd10: glyph_bits = {7'h2A, 7'h1C, 7'h7F, 7'h1C, 7'h2A};
            7'd11: glyph_bits = {7'h08, 7'h08, 7'h3E, 7'h08, 7'h08};
            7'd12: glyph_bits = {7'h00, 7'h50, 7'h30, 7'h00, 7'h00};
            7'd13: glyph_bits = {7'h08, 7'h08, 7'h08, 7'h08, 7'h08};
            7'd14: glyph_bits = {7'h00, 7'h60, 7'h60, 7'h00, 7'h00};
            7'd15: glyph_bits = {7'h20, 7'h10, 7'h08, 7'h04, 7'h02};
            7'd16: glyph_bits = {7'h3E, 7'h51, 7'h49, 7'h45, 7'h3E};
            7'd17: glyph_bits = {7'h00, 7'h42, 7'h7F, 7'h40, 7'h00};
            7'd18: glyph_bits = {7'h42, 7'h61, 7'h51, 7'h49, 7'h46};
            7'd19: glyph_bits = {7'h21, 7'h41, 7'h45, 7'h4B, 7'h31};
            7'd20: glyph_bits = {7'h18, 7'h14, 7'h12, 7'h7F, 7'h10};
            7'd21: glyph_bits = {7'h27, 7'h45, 7'h45, 7'h45, 7'h39};
            7'd22: glyph_bits = {7'h3C, 7'h4A, 7'h49, 7'h49, 7'h30};
            7'd23: glyph_bits = {7'h01, 7'h71, 7'h09, 7'h05, 7'h03};
            7'd24: glyph_bits = {7'h36, 7'h49, 7'h49, 7'h49, 7'h36};
            7'd25: glyph_bits = {7'h06, 7'h49, 7'h49, 7'h29, 7'h1E};
            7'd26: glyph_bits = {7'h00, 7'h36, 7'h36, 7'h00, 7'h00};
            7'd27: glyph_bits = {7'h00, 7'h56, 7'h36, 7'h00, 7'h00};
            7'd28: glyph_bits = {7'h08, 7'h14, 7'h22, 7'h41, 7'h00};
            7'd29: glyph_bits = {7'h14, 7'h14, 7'h14, 7'h14, 7'h14};
            7'd30: glyph_bits = {7'h00, 7'h41, 7'h22, 7'h14, 7'h08};
            7'd31: glyph_bits = {7'h02, 7'h01, 7'h51, 7'h09, 7'h06};
            7'd32: glyph_bits = {7'h32, 7'h49, 7'h79, 7'h41, 7'h3E};
            7'd33: glyph_bits = {7'h7E, 7'h11, 7'h11, 7'h11, 7'h7E};
            7'd34: glyph_bits = {7'h7F, 7'h49, 7'h49, 7'h49, 7'h36};
            7'd35: glyph_bits = {7'h3E, 7'h41, 7'h41, 7'h41, 7'h22};
            7'd36: glyph_bits = {7'h7F, 7'h41, 7'h41, 7'h22, 7'h1C};
            7'd37: glyph_bits = {7'h7F, 7'h49, 7'h49, 7'h49, 7'h41};
            7'd38: glyph_bits = {7'h7F, 7'h09, 7'h09, 7'h09, 7'h01};
            7'd39: glyph_bits = {7'h3E, 7'h41, 7'h49, 7'h49, 7'h7A};
            7'd40: glyph_bits = {7'h7F, 7'h08, 7'h08, 7'h08, 7'h7F};
            7'd41: glyph_bits = {7'h00, 7'h41, 7'h7F, 7'h41, 7'h00};
            7'd42: glyph_bits = {7'h20, 7'h40, 7'h41, 7'h3F, 7'h01};
            7'd43: glyph_bits = {7'h7F, 7'h08, 7'h14, 7'h22, 7'h41};
            7'd44: glyph_bits = {7'h7F, 7'h40, 7'h40, 7'h40, 7'h40};
            7'd45: glyph_bits = {7'h7F, 7'h02, 7'h0C, 7'h02, 7'h7F};
            7'd46: glyph_bits = {7'h7F, 7'h04, 7'h08, 7'h10, 7'h7F};
            7'd47: glyph_bits = {7'h3E, 7'h41, 7'h41, 7'h41, 7'h3E};
            7'd48: glyph_bits = {7'h7F, 7'h09, 7'h09, 7'h09, 7'h06};
            7'd49: glyph_bits = {7'h3E, 7'h41, 7'h51, 7'h21, 7'h5E};
            7'd50: glyph_bits = {7'h7F, 7'h09, 7'h19, 7'h29, 7'h46};
            7'd51: glyph_bits = {7'h46, 7'h49, 7'h49, 7'h49, 7'h31};
            7'd52: glyph_bits = {7'h01, 7'h01, 7'h7F, 7'h01, 7'h01};
            7'd53: glyph_bits = {7'h3F, 7'h40, 7'h40, 7'h40, 7'h3F};
            7'd54: glyph_bits = {7'h1F, 7'h20, 7'h40, 7'h20, 7'h1F};
            7'd55: glyph_bits = {7'h3F, 7'h40, 7'h38, 7'h40, 7'h3F};
            7'd56: glyph_bits = {7'h63, 7'h14, 7'h08, 7'h14, 7'h63};
            7'd57: glyph_bits = {7'h07, 7'h08, 7'h70, 7'h08, 7'h07};
            7'd58: glyph_bits = {7'h61, 7'h51, 7'h49, 7'h45, 7'h43};
            7'd59: glyph_bits = {7'h00, 7'h7F, 7'h41, 7'h41, 7'h00};
            7'd60: glyph_bits = {7'h02, 7'h04, 7'h08, 7'h10, 7'h20};
            7'd61: glyph_bits = {7'h00, 7'h41, 7'h41, 7'h7F, 7'h00};
            7'd62: glyph_bits = {7'h04, 7'h02, 7'h01, 7'h02, 7'h04};
            7'd63: glyph_bits = {7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
            7'd64: glyph_bits = {7'h00, 7'h01, 7'h02, 7'h04, 7'h00};
            7'd65: glyph_bits = {7'h20, 7'h54, 7'h54, 7'h54, 7'h78};
            7'd66: glyph_bits = {7'h7F, 7'h48, 7'h44, 7'h44, 7'h38};
            7'd67: glyph_bits = {7'h38, 7'h44, 7'h44, 7'h44, 7'h20};
            7'd68: glyph_bits = {7'h38, 7'h44, 7'h44, 7'h48, 7'h7F};
            7'd69: glyph_bits = {7'h38, 7'h54, 7'h54, 7'h54, 7'h18};
            7'd70: glyph_bits = {7'h08, 7'h7E, 7'h09, 7'h01, 7'h02};
            7'd71: glyph_bits = {7'h0C, 7'h52, 7'h52, 7'h52, 7'h3E};
            7'd72: glyph_bits = {7'h7F, 7'h08, 7'h04, 7'h04, 7'h78};
            7'd73: glyph_bits = {7'h00, 7'h44, 7'h7D, 7'h40, 7'h00};
            7'd74: glyph_bits = {7'h20, 7'h40, 7'h44, 7'h3D, 7'h00};
            7'd75: glyph_bits = {7'h7F, 7'h10, 7'h28, 7'h44, 7'h00};
            7'd76: glyph_bits = {7'h00, 7'h41, 7'h7F, 7'h40, 7'h00};
            7'd77: glyph_bits = {7'h7C, 7'h04, 7'h18, 7'h04, 7'h78};
            7'd78: glyph_bits = {7'h7C, 7'h08, 7'h04, 7'h04, 7'h78};
            7'd79: glyph_bits = {7'h38, 7'h44, 7'h44, 7'h44, 7'h38};
            7'd80: glyph_bits = {7'h7C, 7'h14, 7'h14, 7'h14, 7'h08};
            7'd81: glyph_bits = {7'h08, 7'h14, 7'h14, 7'h18, 7'h7C};
            7'd82: glyph_bits = {7'h7C, 7'h08, 7'h04, 7'h04, 7'h08};
            7'd83: glyph_bits = {7'h48, 7'h54, 7'h54, 7'h54, 7'h20};
            7'd84: glyph_bits = {7'h04, 7'h3F, 7'h44, 7'h40, 7'h20};
            7'd85: glyph_bits = {7'h3C, 7'h40, 7'h40, 7'h20, 7'h7C};
            7'd86: glyph_bits = {7'h1C, 7'h20, 7'h40, 7'h20, 7'h1C};
            7'd87: glyph_bits = {7'h3C, 7'h40, 7'h30, 7'h40, 7'h3C};
            7'd88: glyph_bits = {7'h44, 7'h28, 7'h10, 7'h28, 7'h44};
            7'd89: glyph_bits = {7'h0C, 7'h50, 7'h50, 7'h50, 7'h3C};
            7'd90: glyph_bits = {7'h44, 7'h64, 7'h54, 7'h4C, 7'h44};
            7'd91: glyph_bits = {7'h00, 7'h08, 7'h36, 7'h41, 7'h00};
            7'd92: glyph_bits = {7'h00, 7'h00, 7'h7F, 7'h00, 7'h00};
            7'd93: glyph_bits = {7'h00, 7'h41, 7'h36, 7'h08, 7'h00};
            7'd94: glyph_bits = {7'h08, 7'h04, 7'h08, 7'h10, 7'h08};
            default: glyph_bits = 35'd0;
        endcase
    endfunction

    // Split the linear address back into glyph index and column, then pick the column.
    always_comb begin
        glyph_idx_s  = 7'(Addr / 9'd5);
        glyph_col_s  = 3'(Addr - (9'(glyph_idx_s) * 9'd5));
        glyph_bits_s = glyph_bits(glyph_idx_s);
        if (Addr < 9'(ROM_DEPTH)) begin
            case (glyph_col_s)
                3'd0:    data_d = glyph_bits_s[34:28];
                3'd1:    data_d = glyph_bits_s[27:21];
                3'd2:    data_d = glyph_bits_s[20:14];
                3'd3:    data_d = glyph_bits_s[13:7];
                3'd4:    data_d = glyph_bits_s[6:0];
                default: data_d = 7'd0;
            endcase
        end else begin
            data_d = 7'd0;
        end
    end

    // Registered read port.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            data_q <= 7'd0;
        end else begin
            data_q <= data_d;
        end
    end

    assign Data = data_q;

endmodule

// File: rtl/char_column_sequencer.sv
// Streams a latched ASCII character to the POV LED bar one font column per ColTick,
// followed by blank gap columns, with a one-deep pending slot for the next character.
module char_column_sequencer #(
    parameter int ROWS      = 7,
    parameter int FONT_COLS = 5,
    parameter int GAP_COLS  = 1
) (
    input  logic            Clock,
    input  logic            Reset,
    input  logic            New,
    input  logic [6:0]      Char,
    input  logic            ColTick,
    output logic [ROWS-1:0] Columns,
    output logic            ColValid,
    output logic            CharDone,
    output logic            Busy,
    output logic            Overrun
);
    import pov_pkg::*;

    state_e          state_q, state_d;
    ascii_t          cur_q, cur_d;
    ascii_t          pend_q, pend_d;
    logic            pend_vld_q, pend_vld_d;
    col_t            col_q, col_d, col_inc_s;
    gap_t            gap_q, gap_d, gap_inc_s;
    logic [6:0]      nxt_q, nxt_d;
    logic [ROWS-1:0] columns_q, columns_d;
    logic            col_valid_q, col_valid_d;
    logic            char_done_q, char_done_d;
    logic            busy_q, busy_d;
    logic            overrun_q, overrun_d;
    logic            finish_s;
    rom_addr_t       rom_addr_s;
    logic [6:0]      rom_data_s;

    assign rom_addr_s = glyph_addr(cur_q, col_q);

    font_rom_5x7 u_font_rom (
        .Clock (Clock),
        .Reset (Reset),
        .Addr  (rom_addr_s),
        .Data  (rom_data_s)
    );

    // Next-state logic for the column FSM, counters and pending slot.
    always_comb begin
        state_d     = state_q;
        cur_d       = cur_q;
        pend_d      = pend_q;
        pend_vld_d  = pend_vld_q;
        col_d       = col_q;
        gap_d       = gap_q;
        nxt_d       = nxt_q;
        columns_d   = columns_q;
        col_valid_d = 1'b0;
        char_done_d = 1'b0;
        overrun_d   = 1'b0;
        finish_s    = 1'b0;
        col_inc_s   = col_q + 3'd1;
        gap_inc_s   = gap_q + 2'd1;

        case (state_q)
            ST_IDLE: begin
                if (New) begin
                    cur_d   = Char;
                    col_d   = 3'd0;
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FETCH: begin
                state_d = ST_LOAD;
            end
            ST_LOAD: begin
                nxt_d   = rom_data_s;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (ColTick) begin
                    columns_d   = ROWS'(nxt_q);
                    col_valid_d = 1'b1;
                    col_d       = col_inc_s;
                    if (col_inc_s < col_t'(FONT_COLS)) begin
                        state_d = ST_FETCH;
                    end else begin
                        gap_d = 2'd0;
                        if (GAP_COLS == 0) begin
                            finish_s = 1'b1;
                        end else begin
                            state_d = ST_GAP;
                        end
                    end
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_GAP: begin
                if (ColTick) begin
                    columns_d   = '0;
                    col_valid_d = 1'b1;
                    gap_d       = gap_inc_s;
                    finish_s    = (gap_inc_s == gap_t'(GAP_COLS));
                end else begin
                    state_d = ST_GAP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A New arriving as the pending slot drains refills that slot without overrun.
        if (finish_s) begin
            char_done_d = 1'b1;
            col_d       = 3'd0;
            if (pend_vld_q) begin
                cur_d      = pend_q;
                pend_vld_d = New;
                pend_d     = New ? Char : pend_q;
                state_d    = ST_FETCH;
            end else if (New) begin
                cur_d   = Char;
                state_d = ST_FETCH;
            end else begin
                state_d = ST_IDLE;
            end
        end else if (New && (state_q != ST_IDLE)) begin
            if (!pend_vld_q) begin
                pend_d     = Char;
                pend_vld_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else begin
            pend_vld_d = pend_vld_q;
        end

        busy_d = (state_d != ST_IDLE) || pend_vld_d;
    end

    // State and registered outputs; Reset discards current and pending characters.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q     <= ST_IDLE;
            cur_q       <= 7'd0;
            pend_q      <= 7'd0;
            pend_vld_q  <= 1'b0;
            col_q       <= 3'd0;
            gap_q       <= 2'd0;
            nxt_q       <= 7'd0;
            columns_q   <= '0;
            col_valid_q <= 1'b0;
            char_done_q <= 1'b0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_q       <= cur_d;
            pend_q      <= pend_d;
            pend_vld_q  <= pend_vld_d;
            col_q       <= col_d;
            gap_q       <= gap_d;
            nxt_q       <= nxt_d;
            columns_q   <= columns_d;
            col_valid_q <= col_valid_d;
            char_done_q <= char_done_d;
            busy_q      <= busy_d;
            overrun_q   <= overrun_d;
        end
    end

    assign Columns  = columns_q;
    assign ColValid = col_valid_q;
    assign CharDone = char_done_q;
    assign Busy     = busy_q;
    assign Overrun  = overrun_q;

endmodule

// File: tb/tb_char_column_sequencer.sv
// Bench for char_column_sequencer: directed scenarios plus random traffic, all
// checked per cycle against a slot-queue reference model.
module tb_char_column_sequencer;

    localparam int ROWS      = 7;
    localparam int FONT_COLS = 5;
    localparam int GAP_COLS  = 1;

    logic            Clock = 1'b0;
    logic            Reset = 1'b1;
    logic            New = 1'b0;
    logic [6:0]      Char = 7'd0;
    logic            ColTick = 1'b0;
    logic [ROWS-1:0] Columns;
    logic            ColValid, CharDone, Busy, Overrun;

    always #5 Clock = ~Clock;

    char_column_sequencer #(.ROWS(ROWS), .FONT_COLS(FONT_COLS), .GAP_COLS(GAP_COLS)) dut (
        .Clock(Clock), .Reset(Reset), .New(New), .Char(Char), .ColTick(ColTick),
        .Columns(Columns), .ColValid(ColValid), .CharDone(CharDone),
        .Busy(Busy), .Overrun(Overrun)
    );

    int checks = 0;
    int errors = 0;

    // reference model state: remaining output slots of the current character
    int         slots[$];
    int         popped = 0;
    bit         active = 1'b0;
    bit         pv = 1'b0;
    logic [6:0] pch = 7'd0;
    int         ready = 0;
    int         cyc = 0;
    logic [6:0] m_cols = 7'd0;
    bit         m_cv = 1'b0, m_cd = 1'b0, m_ov = 1'b0, m_busy = 1'b0;

    int         cv_cnt = 0, cd_cnt = 0, ov_cnt = 0;
    logic [6:0] cap[$];
    logic [6:0] eq[$];
    int         last_tick = -100;
    int         spacing = 3;
    logic [6:0] pool [10] = '{7'h41, 7'h42, 7'h43, 7'h48, 7'h30, 7'h21, 7'h20, 7'h07, 7'h7F, 7'h00};

    function automatic logic [34:0] glyph_of(input logic [6:0] c);
        case (c)
            7'h41:   return {7'h7E, 7'h11, 7'h11, 7'h11, 7'h7E};
            7'h42:   return {7'h7F, 7'h49, 7'h49, 7'h49, 7'h36};
            7'h43:   return {7'h3E, 7'h41, 7'h41, 7'h41, 7'h22};
            7'h48:   return {7'h7F, 7'h08, 7'h08, 7'h08, 7'h7F};
            7'h30:   return {7'h3E, 7'h51, 7'h49, 7'h45, 7'h3E};
            7'h21:   return {7'h00, 7'h00, 7'h5F, 7'h00, 7'h00};
            default: return 35'd0;
        endcase
    endfunction

    task automatic load_char(input logic [6:0] c);
        logic [34:0] g;
        g = glyph_of(c);
        slots.delete();
        for (int k = 0; k < FONT_COLS; k++) slots.push_back(int'(g[34 - 7*k -: 7]));
        for (int k = 0; k < GAP_COLS; k++) slots.push_back(0);
        popped = 0;
        ready  = cyc + 3;
    endtask

    task automatic model_edge(input bit nw, input logic [6:0] ch, input bit tk, input bit rst);
        bit fin;
        fin = 1'b0; m_cv = 1'b0; m_cd = 1'b0; m_ov = 1'b0;
        if (rst) begin
            active = 1'b0; pv = 1'b0; slots.delete(); m_cols = 7'd0;
        end else if (!active) begin
            if (nw) begin active = 1'b1; load_char(ch); end
        end else begin
            if (tk && (cyc >= ready)) begin
                m_cols = 7'(slots.pop_front());
                m_cv   = 1'b1;
                popped++;
                ready  = cyc + ((popped < FONT_COLS) ? 3 : 1);
                fin    = (slots.size() == 0);
            end
            if (fin) begin
                m_cd = 1'b1;
                if (pv) begin
                    load_char(pch);
                    pv  = nw;
                    pch = ch;
                end else if (nw) begin
                    load_char(ch);
                end else begin
                    active = 1'b0;
                end
            end else if (nw) begin
                if (pv) m_ov = 1'b1;
                else begin pv = 1'b1; pch = ch; end
            end
        end
        m_busy = active || pv;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit nw, input logic [6:0] ch, input bit tk, input bit rst);
        New = nw; Char = ch; ColTick = tk; Reset = rst;
        if (tk) last_tick = cyc;
        @(posedge Clock);
        model_edge(nw, ch, tk, rst);
        cyc++;
        #1;
        chk("Columns",  32'(Columns),  32'(m_cols));
        chk("ColValid", 32'(ColValid), 32'(m_cv));
        chk("CharDone", 32'(CharDone), 32'(m_cd));
        chk("Overrun",  32'(Overrun),  32'(m_ov));
        chk("Busy",     32'(Busy),     32'(m_busy));
        if (ColValid) begin cv_cnt++; cap.push_back(Columns); end
        if (CharDone) cd_cnt++;
        if (Overrun) ov_cnt++;
        New = 1'b0; ColTick = 1'b0; Reset = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 7'd0, 1'b0, 1'b0);
    endtask

    task automatic tick8(input int k);
        repeat (k) begin idle(7); step(1'b0, 7'd0, 1'b1, 1'b0); end
    endtask

    task automatic clr();
        cv_cnt = 0; cd_cnt = 0; ov_cnt = 0; cap.delete();
    endtask

    task automatic check_cap(input string tag, input logic [6:0] exp_q[$]);
        chk({tag, "_len"}, 32'(cap.size()), 32'(exp_q.size()));
        for (int i = 0; (i < exp_q.size()) && (i < cap.size()); i++)
            chk(tag, 32'(cap[i]), 32'(exp_q[i]));
    endtask

    initial begin
        step(1'b0, 7'd0, 1'b0, 1'b1);
        step(1'b0, 7'd0, 1'b1, 1'b1);
        chk("reset_busy", 32'(Busy), 32'd0);

        // single 'A'
        clr();
        step(1'b1, 7'h41, 1'b0, 1'b0);
        tick8(6); idle(2);
        eq = '{7'h7E, 7'h11, 7'h11, 7'h11, 7'h7E, 7'h00};
        check_cap("a_cols", eq);
        chk("a_cv", 32'(cv_cnt), 32'd6);
        chk("a_done", 32'(cd_cnt), 32'd1);
        chk("a_busy_end", 32'(Busy), 32'd0);

        // 'B' queued while 'A' is on column 2
        clr();
        step(1'b1, 7'h41, 1'b0, 1'b0);
        tick8(2);
        step(1'b1, 7'h42, 1'b0, 1'b0);
        chk("ab_busy", 32'(Busy), 32'd1);
        tick8(10); idle(2);
        eq = '{7'h7E, 7'h11, 7'h11, 7'h11, 7'h7E, 7'h00, 7'h7F, 7'h49, 7'h49, 7'h49, 7'h36, 7'h00};
        check_cap("ab_cols", eq);
        chk("ab_done", 32'(cd_cnt), 32'd2);
        chk("ab_ovr", 32'(ov_cnt), 32'd0);

        // 'C' dropped while 'B' is pending
        clr();
        step(1'b1, 7'h41, 1'b0, 1'b0);
        step(1'b1, 7'h42, 1'b0, 1'b0);
        step(1'b1, 7'h43, 1'b0, 1'b0);
        tick8(14); idle(2);
        check_cap("abc_cols", eq);
        chk("abc_ovr", 32'(ov_cnt), 32'd1);
        chk("abc_done", 32'(cd_cnt), 32'd2);

        // non-printable code
        clr();
        step(1'b1, 7'h07, 1'b0, 1'b0);
        tick8(6); idle(2);
        eq = '{7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};
        check_cap("np_cols", eq);
        chk("np_done", 32'(cd_cnt), 32'd1);

        // reset after third column discards current and pending
        clr();
        step(1'b1, 7'h41, 1'b0, 1'b0);
        step(1'b1, 7'h42, 1'b0, 1'b0);
        tick8(3);
        step(1'b0, 7'd0, 1'b0, 1'b1);
        chk("rst_busy", 32'(Busy), 32'd0);
        chk("rst_cols", 32'(Columns), 32'd0);
        tick8(6);
        chk("rst_cv", 32'(cv_cnt), 32'd3);
        chk("rst_done", 32'(cd_cnt), 32'd0);

        // ColTick in IDLE and right after New are ignored
        clr();
        step(1'b0, 7'd0, 1'b1, 1'b0);
        idle(3);
        step(1'b1, 7'h41, 1'b0, 1'b0);
        step(1'b0, 7'd0, 1'b1, 1'b0);
        chk("early_cv", 32'(cv_cnt), 32'd0);
        tick8(6); idle(2);
        eq = '{7'h7E, 7'h11, 7'h11, 7'h11, 7'h7E, 7'h00};
        check_cap("late_cols", eq);

        // random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            bit rst, nw, tk;
            rst = ($urandom_range(0, 599) == 0);
            nw  = ($urandom_range(0, 9) == 0);
            tk  = ((cyc - last_tick) >= spacing);
            if (tk) spacing = $urandom_range(3, 9);
            step(nw, pool[$urandom_range(0, 9)], tk, rst);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/char_column_sequencer.md
Name: char_column_sequencer

Overview:
- Downstream consumer of the character-latch stage: takes the latched 7-bit ASCII code plus its one-cycle New strobe and streams the glyph to the POV LED bar one column at a time.
- Each character renders as 5 font columns (5x7 font) followed by GAP_COLS blank columns.
- Column slots are paced by ColTick from the rotation/angle timer.
- Holds one pending character so the upstream stage can load the next char while the current one is still displaying.

Parameters:
- ROWS, 7, LED rows per column (width of Columns).
- FONT_COLS, 5, glyph columns per character.
- GAP_COLS, 1, blank columns emitted after each glyph (range 0..3).

Ports:
- Clock  in  1  system clock.
- Reset  in  1  synchronous, active-high reset.
- New  in  1  one-cycle strobe: Char holds a new code.
- Char  in  7  ASCII code, sampled only when New=1.
- ColTick  in  1  one-cycle strobe, start of next column slot.
- Columns  out  ROWS  LED pattern for the current slot; bit0 = top row.
- ColValid  out  1  one-cycle pulse when Columns is updated.
- CharDone  out  1  one-cycle pulse after the last gap column of a character.
- Busy  out  1  high when state is not IDLE or the pending slot is full.
- Overrun  out  1  one-cycle pulse when a New is dropped.

Behaviour:
- Reset (synchronous, active-high; dominates every other input): Columns=0, ColValid=0, CharDone=0, Overrun=0, Busy=0, state=IDLE, pending empty, col=0, gap=0.
- State machine: IDLE, FETCH, LOAD, WAIT, GAP.
  - IDLE: on New, cur<=Char, col<=0, go to FETCH. ColTick in IDLE is ignored: Columns stays 0, no ColValid.
  - FETCH: drive ROM address for (cur,col), go to LOAD.
  - LOAD: capture ROM data into nxt, go to WAIT.
  - WAIT: on ColTick, Columns<=nxt, ColValid=1, col++.
    - If the new col < FONT_COLS, go to FETCH.
    - Otherwise gap<=0 and go to GAP. If GAP_COLS=0, take the GAP exit actions immediately instead.
  - GAP: on ColTick, Columns<=0, ColValid=1, gap++. When gap reaches GAP_COLS:
    - pulse CharDone;
    - if pending is full, cur<=pending, clear pending, col<=0, go to FETCH;
    - else if New is high this cycle, cur<=Char, go to FETCH;
    - else go to IDLE. Columns keeps 0.
- Font ROM read latency is 1 cycle. Address = (cur-0x20)*FONT_COLS+col.
- Codes outside 0x20..0x7E read all-zero, so they render as blank columns but still take the full slot count.
- ColTick in FETCH or LOAD is ignored (slot missed). ColTick spacing must be at least 3 Clock cycles; the integration constraint is that the angle timer guarantees this.
- Pending slot (1 deep):
  - New while state is not IDLE: if pending is empty, pending<=Char; if full, drop the new code and pulse Overrun.
  - If New arrives in the same cycle pending drains, the new code goes into the just-freed slot; no Overrun.
- Columns holds its value between ticks. Only the tick cycle changes it.
- Latency: New in IDLE means Columns can update on a ColTick no earlier than cycle +3.
- Reset mid-character discards cur and pending. No CharDone is issued.

Decomposition:
- Shared package (pov_pkg):
  - constants ROWS, FONT_COLS, ASCII_FIRST=0x20, ASCII_LAST=0x7E;
  - state enum encoding;
  - col_t / ascii_t widths.
- Sub-module font_rom_5x7: 480 x 7-bit registered ROM, 1-cycle latency, out-of-range returns 0.
- Sequencer FSM, pending register and counters stay in the top module.

Test Plan:
- Reset, then New with Char=0x41 ('A'), 6 ColTicks spaced 8 cycles -> Columns = 0x7E,0x11,0x11,0x11,0x7E,0x00; 6 ColValid pulses; CharDone on the 6th tick cycle; Busy falls.
- New 'A', then New 'B' (0x42) during col 2 -> Busy stays high; after the 'A' gap, 'B' columns 0x7F,0x49,0x49,0x49,0x36 then 0x00; one CharDone per character; no Overrun.
- New 'A' followed by New 'B' and New 'C' while 'A' is still displaying -> one Overrun pulse on the 'C' cycle; only 'A' and 'B' are displayed.
- Char=0x07 (non-printable) -> 6 slots all 0x00, CharDone issued.
- Reset asserted after the 3rd column of 'A' -> next cycle Columns=0, Busy=0; further ColTicks produce no ColValid; a pending char is discarded.
- ColTick in IDLE, and ColTick one cycle after New -> no ColValid; the first glyph column appears on the next tick arriving in WAIT.
